tcp_mem_tx_mux: RTL and testbench

- Sits directly downstream of the TCP memory round-robin arbiter.
- Consumes the arbiter's one-hot select, select-ready and port number. It then reads one frame from the selected per-connection TX buffer and emits it as a single valid/ready word stream toward the TCP/IP header inserter.
- Returns stop_o to the arbiter when the frame is done so the next round-robin grant can start.
- Holds sel_block_o while busy, so no new grant arrives mid-frame.

---
 rtl/tcp_mem_tx_mux_if.sv | 23 ++
 rtl/tcp_mem_tx_mux.sv | 189 ++++++++++++++++++
 tb/tb_tcp_mem_tx_mux.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcp_mem_tx_mux_if.sv
// Word stream from the TX mux toward the TCP/IP header inserter.
// The mux drives through the master modport; the downstream consumer uses slave.
interface tcp_mem_tx_mux_if #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 3
);
    logic [DATA_W-1:0] tx_data_o;
    logic              tx_vld_o;
    logic              tx_sop_o;
    logic              tx_eop_o;
    logic [SEL_W-1:0]  tx_port_o;
    logic              tx_rdy_i;

    modport master (
        output tx_data_o, tx_vld_o, tx_sop_o, tx_eop_o, tx_port_o,
        input  tx_rdy_i
    );

    modport slave (
        input  tx_data_o, tx_vld_o, tx_sop_o, tx_eop_o, tx_port_o,
        output tx_rdy_i
    );
endinterface

// File: rtl/tcp_mem_tx_mux.sv
// Reads one frame from the arbiter-selected TX buffer and streams it out,
// handing stop_o back to the arbiter once the last word has been accepted.
module tcp_mem_tx_mux #(
    parameter int DEVICE_NUM = 4,
    parameter int DATA_W     = 16,
    parameter int LEN_W      = 11,
    parameter int SEL_W      = $clog2(DEVICE_NUM + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DEVICE_NUM-1:0]        sel_i,
    input  logic                         sel_rdy_i,
    input  logic [SEL_W-1:0]             port_number_i,
    input  logic [DEVICE_NUM*LEN_W-1:0]  dev_len_i,
    input  logic [DEVICE_NUM*DATA_W-1:0] dev_data_i,
    output logic [DEVICE_NUM-1:0]        dev_rd_o,
    output logic [DEVICE_NUM-1:0]        dev_done_o,
    output logic                         stop_o,
    output logic                         sel_block_o,
    output logic                         sel_err_o,
    tcp_mem_tx_mux_if.master             tx
);

    localparam int               IDX_W    = (DEVICE_NUM > 1) ? $clog2(DEVICE_NUM) : 1;
    localparam logic [SEL_W-1:0] PORT_MAX = SEL_W'(DEVICE_NUM - 1);

    typedef enum logic [2:0] {IDLE, LOAD, READ, DRAIN, DONE} state_t;

    state_t                  state_reg;
    logic [SEL_W-1:0]        port_reg;
    logic [LEN_W-1:0]        len_reg;
    logic [LEN_W-1:0]        rd_cnt_reg;
    logic [LEN_W-1:0]        tx_cnt_reg;
    logic                    sel_rdy_q_reg;
    logic                    stop_reg;
    logic [DEVICE_NUM-1:0]   done_reg;
    logic                    block_reg;
    logic                    sel_err_reg;
    logic                    infl_reg;

    logic [DATA_W-1:0]       fifo_mem [2];
    logic                    wr_ptr_reg;
    logic                    rd_ptr_reg;
    logic [1:0]              buf_cnt_reg;

    logic [LEN_W-1:0]        dev_len_arr  [DEVICE_NUM];
    logic [DATA_W-1:0]       dev_data_arr [DEVICE_NUM];
    logic [DEVICE_NUM-1:0]   port_oh;
    logic [DEVICE_NUM-1:0]   start_oh;

    logic                    start;
    logic                    port_ok;
    logic [IDX_W-1:0]        port_idx;
    logic [1:0]              occ;
    logic                    rd_en;
    logic                    tx_vld;
    logic                    xfer;
    logic                    last_xfer;

    assign port_ok  = (port_reg <= PORT_MAX);
    assign port_idx = port_reg[IDX_W-1:0];
    assign start    = sel_rdy_i & ~sel_rdy_q_reg & (state_reg == IDLE);

    // Words buffered plus the read whose data arrives next cycle must leave room.
    assign occ      = buf_cnt_reg + {1'b0, infl_reg};
    assign rd_en    = (state_reg == READ) && (rd_cnt_reg < len_reg) && (occ < 2'd2);

    assign tx_vld    = (buf_cnt_reg != 2'd0);
    assign xfer      = tx_vld & tx.tx_rdy_i;
    assign last_xfer = xfer && (tx_cnt_reg == len_reg - LEN_W'(1));

    generate
        for (genvar gi = 0; gi < DEVICE_NUM; gi++) begin : g_dev
            assign dev_len_arr[gi]  = dev_len_i[gi*LEN_W +: LEN_W];
            assign dev_data_arr[gi] = dev_data_i[gi*DATA_W +: DATA_W];
            assign port_oh[gi]      = (port_reg == SEL_W'(gi));
            assign start_oh[gi]     = (port_number_i == SEL_W'(gi));
            assign dev_rd_o[gi]     = rd_en & port_oh[gi];
        end
    endgenerate

    assign tx.tx_data_o = fifo_mem[rd_ptr_reg];
    assign tx.tx_vld_o  = tx_vld;
    assign tx.tx_sop_o  = tx_vld && (tx_cnt_reg == '0);
    assign tx.tx_eop_o  = tx_vld && (tx_cnt_reg == len_reg - LEN_W'(1));
    assign tx.tx_port_o = port_reg;

    assign stop_o      = stop_reg;
    assign dev_done_o  = done_reg;
    assign sel_block_o = block_reg;
    assign sel_err_o   = sel_err_reg;

    // Two-entry output FIFO; a word is written the cycle after its read strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr_reg  <= 1'b0;
            rd_ptr_reg  <= 1'b0;
            buf_cnt_reg <= 2'd0;
        end else begin
            if (infl_reg) begin
                fifo_mem[wr_ptr_reg] <= dev_data_arr[port_idx];
                wr_ptr_reg           <= ~wr_ptr_reg;
            end
            if (xfer) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({infl_reg, xfer})
                2'b10:   buf_cnt_reg <= buf_cnt_reg + 2'd1;
                2'b01:   buf_cnt_reg <= buf_cnt_reg - 2'd1;
                default: buf_cnt_reg <= buf_cnt_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            port_reg      <= '0;
            len_reg       <= '0;
            rd_cnt_reg    <= '0;
            tx_cnt_reg    <= '0;
            sel_rdy_q_reg <= 1'b0;
            stop_reg      <= 1'b0;
            done_reg      <= '0;
            block_reg     <= 1'b0;
            sel_err_reg   <= 1'b0;
            infl_reg      <= 1'b0;
        end else begin
            sel_rdy_q_reg <= sel_rdy_i;
            stop_reg      <= 1'b0;
            done_reg      <= '0;
            infl_reg      <= rd_en;
            if (rd_en) begin
                rd_cnt_reg <= rd_cnt_reg + LEN_W'(1);
            end
            if (xfer) begin
                tx_cnt_reg <= tx_cnt_reg + LEN_W'(1);
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        port_reg    <= port_number_i;
                        sel_err_reg <= (sel_i != start_oh);
                        block_reg   <= 1'b1;
                        state_reg   <= LOAD;
                    end
                end
                LOAD: begin
                    // An out-of-range port number is closed out as an empty frame.
                    len_reg    <= port_ok ? dev_len_arr[port_idx] : '0;
                    rd_cnt_reg <= '0;
                    tx_cnt_reg <= '0;
                    if (!port_ok || dev_len_arr[port_idx] == '0) begin
                        stop_reg  <= 1'b1;
                        done_reg  <= port_oh;
                        state_reg <= DONE;
                    end else begin
                        state_reg <= READ;
                    end
                end
                READ: begin
                    if (rd_cnt_reg == len_reg) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_xfer || tx_cnt_reg == len_reg) begin
                        stop_reg  <= 1'b1;
                        done_reg  <= port_oh;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    block_reg <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    block_reg <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tcp_mem_tx_mux.sv
// Directed frame sequence with random payloads; each delivered frame is compared
// against the words the bench placed in the selected device buffer.
module tb_tcp_mem_tx_mux;

    localparam int DEVICE_NUM = 4;
    localparam int DATA_W     = 16;
    localparam int LEN_W      = 11;
    localparam int SEL_W      = 3;
    localparam int MEM_D      = 16;
    localparam int MAX_CYC    = 400;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DEVICE_NUM-1:0]        sel_i = '0;
    logic                         sel_rdy_i = 1'b0;
    logic [SEL_W-1:0]             port_number_i = '0;
    logic [DEVICE_NUM*LEN_W-1:0]  dev_len_i = '0;
    logic [DEVICE_NUM*DATA_W-1:0] dev_data_i;
    logic [DEVICE_NUM-1:0]        dev_rd_o;
    logic [DEVICE_NUM-1:0]        dev_done_o;
    logic                         stop_o;
    logic                         sel_block_o;
    logic                         sel_err_o;

    tcp_mem_tx_mux_if #(.DATA_W(DATA_W), .SEL_W(SEL_W)) tx_if ();

    tcp_mem_tx_mux #(
        .DEVICE_NUM(DEVICE_NUM), .DATA_W(DATA_W), .LEN_W(LEN_W), .SEL_W(SEL_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sel_i         (sel_i),
        .sel_rdy_i     (sel_rdy_i),
        .port_number_i (port_number_i),
        .dev_len_i     (dev_len_i),
        .dev_data_i    (dev_data_i),
        .dev_rd_o      (dev_rd_o),
        .dev_done_o    (dev_done_o),
        .stop_o        (stop_o),
        .sel_block_o   (sel_block_o),
        .sel_err_o     (sel_err_o),
        .tx            (tx_if)
    );

    // Device buffers: a strobe returns the next stored word one cycle later.
    logic [DATA_W-1:0] mem   [DEVICE_NUM][MEM_D];
    logic [3:0]        ptr   [DEVICE_NUM];
    logic [DATA_W-1:0] dev_q [DEVICE_NUM];

    always @(posedge clk) begin
        for (int k = 0; k < DEVICE_NUM; k++) begin
            if (dev_rd_o[k]) begin
                dev_q[k] <= mem[k][ptr[k]];
                ptr[k] = ptr[k] + 4'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEVICE_NUM; gi++) begin : g_dq
            assign dev_data_i[gi*DATA_W +: DATA_W] = dev_q[gi];
        end
    endgenerate

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation records, filled on the falling edge.
    logic [DATA_W-1:0]       q_data [$];
    logic                    q_sop  [$];
    logic                    q_eop  [$];
    logic [SEL_W-1:0]        q_port [$];
    int                      stop_cnt, stop_cyc, done_cnt, eop_cyc, port_chg_cyc;
    int                      stall_err, rd_err, rd_cycles, strobes, xfers;
    logic [DEVICE_NUM-1:0]   done_at_stop, rd_or;
    logic                    vld_seen, prev_stall;
    logic [DATA_W+SEL_W+2:0] prev_vec;
    logic [SEL_W-1:0]        prev_port = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall && ({tx_if.tx_data_o, tx_if.tx_sop_o, tx_if.tx_eop_o,
                                tx_if.tx_port_o, tx_if.tx_vld_o} != prev_vec))
                stall_err++;
            if (tx_if.tx_port_o != prev_port) port_chg_cyc = cyc;
            if (dev_rd_o != '0) begin
                rd_cycles++;
                rd_or = rd_or | dev_rd_o;
                if ($countones(dev_rd_o) != 1 || (strobes - xfers) >= 2) rd_err++;
                strobes++;
            end
            if (tx_if.tx_vld_o) vld_seen = 1'b1;
            if (tx_if.tx_vld_o && tx_if.tx_rdy_i) begin
                q_data.push_back(tx_if.tx_data_o);
                q_sop.push_back(tx_if.tx_sop_o);
                q_eop.push_back(tx_if.tx_eop_o);
                q_port.push_back(tx_if.tx_port_o);
                xfers++;
                if (tx_if.tx_eop_o) eop_cyc = cyc;
            end
            if (stop_o) begin
                stop_cnt++;
                stop_cyc     = cyc;
                done_at_stop = dev_done_o;
            end
            if (dev_done_o != '0) done_cnt++;
            prev_stall = tx_if.tx_vld_o & ~tx_if.tx_rdy_i;
            prev_vec   = {tx_if.tx_data_o, tx_if.tx_sop_o, tx_if.tx_eop_o,
                          tx_if.tx_port_o, tx_if.tx_vld_o};
            prev_port  = tx_if.tx_port_o;
        end
    end

    int n_cmp = 0;
    int n_mis = 0;
    int t0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        q_data.delete(); q_sop.delete(); q_eop.delete(); q_port.delete();
        stop_cnt = 0; stop_cyc = -1; done_cnt = 0; eop_cyc = -1; port_chg_cyc = -1;
        stall_err = 0; rd_err = 0; rd_cycles = 0; strobes = 0; xfers = 0;
        done_at_stop = '0; rd_or = '0; vld_seen = 1'b0; prev_stall = 1'b0;
    endtask

    // Called just after a rising edge; raises sel_rdy_i for a new grant.
    task automatic setup_frame(input int p, input int len, input bit bad_sel);
        for (int i = 0; i < MEM_D; i++) mem[p][i] = DATA_W'($urandom);
        for (int k = 0; k < DEVICE_NUM; k++) ptr[k] = 4'd0;
        dev_len_i = (DEVICE_NUM*LEN_W)'({$urandom, $urandom});
        dev_len_i[p*LEN_W +: LEN_W] = LEN_W'(len);
        sel_i = bad_sel ? DEVICE_NUM'(1 << ((p + 1) % DEVICE_NUM)) : DEVICE_NUM'(1 << p);
        port_number_i = SEL_W'(p);
        clear_mon();
        tx_if.tx_rdy_i = 1'b1;
        sel_rdy_i = 1'b1;
        t0 = cyc;
    endtask

    // mode 0: always ready, 1: alternating 1010..., 2: random
    task automatic wait_stop(input int mode, input bit glitch);
        int n = 0;
        while (stop_cnt == 0 && n < MAX_CYC) begin
            @(posedge clk); #1;
            n++;
            if (n == 2) dev_len_i = (DEVICE_NUM*LEN_W)'({$urandom, $urandom});
            if (glitch && n == 4) sel_rdy_i = 1'b0;
            if (glitch && n == 5) sel_rdy_i = 1'b1;
            case (mode)
                0:       tx_if.tx_rdy_i = 1'b1;
                1:       tx_if.tx_rdy_i = (n % 2 == 0);
                default: tx_if.tx_rdy_i = 1'($urandom % 2);
            endcase
        end
        chk("stop_timeout", longint'(n < MAX_CYC), 1);
        sel_rdy_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_frame(input int p, input int len, input bit bad_sel);
        logic [DEVICE_NUM-1:0] exp_oh;
        exp_oh = DEVICE_NUM'(1 << p);
        chk($sformatf("p%0d_len%0d_words", p, len), q_data.size(), len);
        for (int i = 0; i < len && i < q_data.size(); i++) begin
            chk($sformatf("p%0d_w%0d_data", p, i), q_data[i], mem[p][i]);
            chk($sformatf("p%0d_w%0d_sop", p, i), q_sop[i], longint'(i == 0));
            chk($sformatf("p%0d_w%0d_eop", p, i), q_eop[i], longint'(i == len - 1));
            chk($sformatf("p%0d_w%0d_port", p, i), q_port[i], p);
        end
        chk("stop_pulses", stop_cnt, 1);
        chk("done_pulses", done_cnt, 1);
        chk("done_vector", done_at_stop, exp_oh);
        chk("rd_cycles", rd_cycles, len);
        if (len > 0) begin
            chk("stop_after_eop", stop_cyc - eop_cyc, 1);
            chk("rd_vector", rd_or, exp_oh);
        end else begin
            chk("stop_after_start", stop_cyc - t0, 2);
            chk("no_vld_empty", vld_seen, 0);
        end
        chk("rd_flow_ctrl", rd_err, 0);
        chk("stall_stable", stall_err, 0);
        chk("sel_err", sel_err_o, longint'(bad_sel));
        chk("block_idle", sel_block_o, 0);
    endtask

    task automatic run_frame(input int p, input int len, input int mode,
                             input bit glitch, input bit bad_sel);
        setup_frame(p, len, bad_sel);
        wait_stop(mode, glitch);
        check_frame(p, len, bad_sel);
        $display("frame port=%0d len=%0d mode=%0d words=%0d stop_cyc=%0d",
                 p, len, mode, q_data.size(), stop_cyc);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd"}, dev_rd_o, 0);
        chk({tag, "_done"}, dev_done_o, 0);
        chk({tag, "_stop"}, stop_o, 0);
        chk({tag, "_block"}, sel_block_o, 0);
        chk({tag, "_vld"}, tx_if.tx_vld_o, 0);
        chk({tag, "_sop_eop"}, {tx_if.tx_sop_o, tx_if.tx_eop_o}, 0);
        chk({tag, "_data"}, tx_if.tx_data_o, 0);
        chk({tag, "_port"}, tx_if.tx_port_o, 0);
    endtask

    initial begin
        int saved_eop;
        int n;
        tx_if.tx_rdy_i = 1'b0;
        for (int k = 0; k < DEVICE_NUM; k++) ptr[k] = 4'd0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_frame(2, 5, 0, 1'b0, 1'b0);
        run_frame(1, 8, 1, 1'b0, 1'b0);
        run_frame(0, 0, 0, 1'b0, 1'b0);
        run_frame(3, 1, 0, 1'b0, 1'b0);

        run_frame(1, 4, 0, 1'b0, 1'b0);
        saved_eop = eop_cyc;
        run_frame(3, 3, 0, 1'b0, 1'b0);
        chk("port_chg_after_eop", longint'(port_chg_cyc > saved_eop), 1);

        run_frame(0, 7, 2, 1'b1, 1'b0);
        run_frame(2, 3, 0, 1'b0, 1'b1);

        // Abort a len-10 frame while word 3 is presented.
        setup_frame(2, 10, 1'b0);
        n = 0;
        while (q_data.size() < 3 && n < MAX_CYC) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_reach_word3", longint'(n < MAX_CYC), 1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        sel_rdy_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_stop", stop_cnt, 0);
        chk("abort_no_done", done_cnt, 0);
        $display("abort port=2 len=10 words_before_reset=%0d", q_data.size());
        run_frame(2, 2, 0, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            int p, len;
            p   = $urandom_range(0, DEVICE_NUM - 1);
            len = $urandom_range(0, 12);
            run_frame(p, len, $urandom_range(0, 2), (len >= 6) && ($urandom % 2 == 1), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
